// File: rtl/wb_dma_burst_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wb_dma_burst_master                                          |
// | Description : Multi-channel round-robin Wishbone burst initiator feeding   |
// |               the PCI bridge WBS_* port. Splits each channel transfer     |
// |               into incrementing bursts of up to MAX_BURST beats and       |
// |               handles RTY (re-issue after RETRY_GAP idle cycles) and ERR. |
// |               Optional response timeout: define WB_DMA_TIMEOUT_EN.        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module wb_dma_burst_master #(
  parameter int NUM_CH      = 2,
  parameter int MAX_BURST   = 16,
  parameter int LEN_W       = 16,
  parameter int RETRY_GAP   = 4,
  parameter int TIMEOUT_CYC = 256,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    WB_CLK,
  input  logic                    WB_RST,
  input  logic [NUM_CH-1:0]       CH_REQ,
  input  logic [NUM_CH-1:0]       CH_WE,
  input  logic [NUM_CH*32-1:0]    CH_ADDR,
  input  logic [NUM_CH*LEN_W-1:0] CH_LEN,
  output logic [NUM_CH-1:0]       CH_BUSY,
  output logic [NUM_CH-1:0]       CH_DONE,
  output logic [NUM_CH-1:0]       CH_ERR,
  input  logic [31:0]             WR_DAT,
  input  logic                    WR_VALID,
  output logic                    WR_READY,
  output logic [CH_W-1:0]         WR_CH,
  output logic [31:0]             RD_DAT,
  output logic                    RD_VALID,
  output logic [CH_W-1:0]         RD_CH,
  output logic [31:0]             WBM_ADR_O,
  output logic [31:0]             WBM_DAT_O,
  output logic [3:0]              WBM_SEL_O,
  output logic                    WBM_CYC_O,
  output logic                    WBM_STB_O,
  output logic                    WBM_WE_O,
  output logic [2:0]              WBM_CTI_O,
  output logic [1:0]              WBM_BTE_O,
  input  logic [31:0]             WBM_DAT_I,
  input  logic                    WBM_ACK_I,
  input  logic                    WBM_RTY_I,
  input  logic                    WBM_ERR_I
);

  localparam int BC_W  = $clog2(MAX_BURST) + 1;
  localparam int GAP_W = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARB   = 3'd1;
  localparam logic [2:0] S_BURST = 3'd2;
  localparam logic [2:0] S_NEXT  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [CH_W-1:0]  cur_q, cur_d, last_q, last_d;
  logic [BC_W-1:0]  bcnt_q, bcnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [NUM_CH-1:0] busy_q, we_q, err_q;
  logic [31:0]      addr_q [NUM_CH];
  logic [LEN_W-1:0] rem_q  [NUM_CH];
  logic [31:0]      rd_dat_q;
  logic             rd_valid_q;
  logic [CH_W-1:0]  rd_ch_q;

  logic             w_in_burst, w_stb, w_tmo, w_err_ev, w_rty_ev, w_ack_ev, w_grant;
  logic             w_hi_ok, w_any_ok;
  logic [CH_W-1:0]  w_hi_ch, w_any_ch, w_gnt;
  logic [LEN_W-1:0] w_gnt_rem;
  logic [BC_W-1:0]  w_gnt_n;

  // Bus handshake qualification; ERR (or timeout) outranks RTY, RTY outranks ACK
  assign w_in_burst = (state_q == S_BURST);
  assign w_stb      = w_in_burst & (we_q[cur_q] ? WR_VALID : 1'b1);
  assign w_err_ev   = w_in_burst & (WBM_ERR_I | w_tmo);
  assign w_rty_ev   = w_in_burst & ~w_err_ev & WBM_RTY_I;
  assign w_ack_ev   = w_stb & ~w_err_ev & ~WBM_RTY_I & WBM_ACK_I;

`ifdef WB_DMA_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q;

  // Response watchdog: cleared outside bursts and on any bridge response
  always_ff @(posedge WB_CLK) begin
    if (WB_RST || !w_in_burst || WBM_ACK_I || WBM_RTY_I || WBM_ERR_I) tmo_q <= '0;
    else                                                              tmo_q <= tmo_q + 1'b1;
  end
  assign w_tmo = w_in_burst & (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
`else
  assign w_tmo = 1'b0;
`endif

  // Round-robin pick: first busy channel above the last served one, else lowest busy
  always_comb begin
    w_hi_ok  = 1'b0;
    w_any_ok = 1'b0;
    w_hi_ch  = '0;
    w_any_ch = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (busy_q[CH_W'(c)]) begin
        w_any_ok = 1'b1;
        w_any_ch = CH_W'(c);
        if (CH_W'(c) > last_q) begin
          w_hi_ok = 1'b1;
          w_hi_ch = CH_W'(c);
        end
      end
    end
    w_gnt     = w_hi_ok ? w_hi_ch : w_any_ch;
    w_gnt_rem = rem_q[w_gnt];
    w_gnt_n   = (32'(w_gnt_rem) >= 32'(MAX_BURST)) ? BC_W'(MAX_BURST) : BC_W'(w_gnt_rem);
  end

  // Sequencer; NEXT and the last GAP cycle arbitrate directly so CYC-low time stays minimal
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    last_d  = last_q;
    bcnt_d  = bcnt_q;
    gap_d   = gap_q;
    w_grant = 1'b0;
    case (state_q)
      S_IDLE:  if (|busy_q) state_d = S_ARB;
      S_ARB:   w_grant = 1'b1;
      S_BURST: begin
        if (w_err_ev) begin
          state_d = S_IDLE;
        end else if (w_rty_ev) begin
          state_d = S_GAP;
          gap_d   = GAP_W'(RETRY_GAP - 1);
        end else if (w_ack_ev) begin
          bcnt_d = bcnt_q - 1'b1;
          if (bcnt_q == BC_W'(1)) state_d = S_NEXT;
        end
      end
      S_NEXT:  if (rem_q[cur_q] == '0) state_d = S_FIN;
               else                    w_grant = 1'b1;
      S_GAP:   if (gap_q == '0) w_grant = 1'b1;
               else             gap_d   = gap_q - 1'b1;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (w_grant) begin
      if (w_any_ok) begin
        cur_d   = w_gnt;
        last_d  = w_gnt;
        bcnt_d  = w_gnt_n;
        state_d = (w_gnt_rem == '0) ? S_FIN : S_BURST;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  // Sequencer registers
  always_ff @(posedge WB_CLK) begin
    if (WB_RST) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      last_q  <= CH_W'(NUM_CH - 1);
      bcnt_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      bcnt_q  <= bcnt_d;
      gap_q   <= gap_d;
    end
  end

  // Per-channel request capture, address/length progress and completion
  always_ff @(posedge WB_CLK) begin
    if (WB_RST) begin
      busy_q <= '0;
      we_q   <= '0;
      err_q  <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        addr_q[c] <= '0;
        rem_q[c]  <= '0;
      end
    end else begin
      err_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (CH_REQ[c] && !busy_q[c]) begin
          busy_q[c] <= 1'b1;
          we_q[c]   <= CH_WE[c];
          addr_q[c] <= CH_ADDR[c*32 +: 32];
          rem_q[c]  <= CH_LEN[c*LEN_W +: LEN_W];
        end else if (busy_q[c] && (cur_q == CH_W'(c))) begin
          if (w_ack_ev) begin
            addr_q[c] <= addr_q[c] + 32'd4;
            rem_q[c]  <= rem_q[c] - LEN_W'(1);
          end
          if (w_err_ev) begin
            busy_q[c] <= 1'b0;
            err_q[c]  <= 1'b1;
          end
          if (state_q == S_FIN) busy_q[c] <= 1'b0;
        end
      end
    end
  end

  // Registered read-data return path
  always_ff @(posedge WB_CLK) begin
    if (WB_RST) begin
      rd_dat_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_ch_q    <= '0;
    end else begin
      rd_valid_q <= w_ack_ev & ~we_q[cur_q];
      if (w_ack_ev && !we_q[cur_q]) begin
        rd_dat_q <= WBM_DAT_I;
        rd_ch_q  <= cur_q;
      end
    end
  end

  assign CH_BUSY   = busy_q;
  assign CH_DONE   = (state_q == S_FIN) ? (NUM_CH'(1) << cur_q) : '0;
  assign CH_ERR    = err_q;
  assign WR_READY  = w_ack_ev & we_q[cur_q];
  assign WR_CH     = cur_q;
  assign RD_DAT    = rd_dat_q;
  assign RD_VALID  = rd_valid_q;
  assign RD_CH     = rd_ch_q;
  assign WBM_CYC_O = w_in_burst;
  assign WBM_STB_O = w_stb;
  assign WBM_SEL_O = w_in_burst ? 4'hF : 4'h0;
  assign WBM_WE_O  = w_in_burst & we_q[cur_q];
  assign WBM_ADR_O = w_in_burst ? addr_q[cur_q] : 32'h0;
  assign WBM_DAT_O = (w_in_burst && we_q[cur_q]) ? WR_DAT : 32'h0;
  assign WBM_CTI_O = w_in_burst ? ((bcnt_q == BC_W'(1)) ? 3'b111 : 3'b010) : 3'b000;
  assign WBM_BTE_O = 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_wb_dma_burst_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_wb_dma_burst_master                                       |
// | Description : Scoreboard bench for wb_dma_burst_master with a simple       |
// |               bridge model (ACK / RTY / ERR injection, optional silence).  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_wb_dma_burst_master;
  localparam int NUM_CH = 2;
  localparam int LEN_W  = 16;

  logic              WB_CLK = 1'b0;
  logic              WB_RST = 1'b1;
  logic [1:0]        CH_REQ = '0, CH_WE = '0;
  logic [63:0]       CH_ADDR = '0;
  logic [31:0]       CH_LEN = '0;
  logic [1:0]        CH_BUSY, CH_DONE, CH_ERR;
  logic [31:0]       WR_DAT;
  logic              WR_VALID = 1'b1;
  logic              WR_READY;
  logic [0:0]        WR_CH, RD_CH;
  logic [31:0]       RD_DAT;
  logic              RD_VALID;
  logic [31:0]       WBM_ADR_O, WBM_DAT_O;
  logic [3:0]        WBM_SEL_O;
  logic              WBM_CYC_O, WBM_STB_O, WBM_WE_O;
  logic [2:0]        WBM_CTI_O;
  logic [1:0]        WBM_BTE_O;
  logic [31:0]       WBM_DAT_I = '0;
  logic              WBM_ACK_I = 1'b0, WBM_RTY_I = 1'b0, WBM_ERR_I = 1'b0;

  wb_dma_burst_master #(.NUM_CH(2), .MAX_BURST(16), .LEN_W(16), .RETRY_GAP(4), .TIMEOUT_CYC(256)) dut (
    .WB_CLK(WB_CLK), .WB_RST(WB_RST), .CH_REQ(CH_REQ), .CH_WE(CH_WE), .CH_ADDR(CH_ADDR),
    .CH_LEN(CH_LEN), .CH_BUSY(CH_BUSY), .CH_DONE(CH_DONE), .CH_ERR(CH_ERR),
    .WR_DAT(WR_DAT), .WR_VALID(WR_VALID), .WR_READY(WR_READY), .WR_CH(WR_CH),
    .RD_DAT(RD_DAT), .RD_VALID(RD_VALID), .RD_CH(RD_CH),
    .WBM_ADR_O(WBM_ADR_O), .WBM_DAT_O(WBM_DAT_O), .WBM_SEL_O(WBM_SEL_O), .WBM_CYC_O(WBM_CYC_O),
    .WBM_STB_O(WBM_STB_O), .WBM_WE_O(WBM_WE_O), .WBM_CTI_O(WBM_CTI_O), .WBM_BTE_O(WBM_BTE_O),
    .WBM_DAT_I(WBM_DAT_I), .WBM_ACK_I(WBM_ACK_I), .WBM_RTY_I(WBM_RTY_I), .WBM_ERR_I(WBM_ERR_I)
  );

  always #5 WB_CLK = ~WB_CLK;

  typedef struct packed {logic [31:0] adr; logic [2:0] cti; logic we; logic [31:0] dat; logic ch;} beat_t;
  typedef struct packed {logic [31:0] dat; logic ch;} rd_t;

  beat_t exp_q[$], got_q[$];
  rd_t   exp_rd[$], got_rd[$];
  int    gaps[$];
  int    low_run, done_cnt[2], err_cnt[2], wr_rdy_cnt;
  bit    cyc_seen;
  int    beat_no, rty_at, err_at;
  bit    silent, stall_en;
  int    total, bad;

  function automatic logic [31:0] rd_pat(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction
  function automatic logic [31:0] wr_pat(input logic [31:0] a);
    return a ^ 32'hC3C3_3C3C;
  endfunction

  assign WR_DAT = wr_pat(WBM_ADR_O);

  // Write source: optionally withholds data to create wait beats
  always @(posedge WB_CLK) begin
    #2;
    WR_VALID = stall_en ? ($urandom_range(3) != 0) : 1'b1;
  end

  // Bridge model: responds to each presented strobe
  always @(negedge WB_CLK) begin
    WBM_ACK_I = 1'b0; WBM_RTY_I = 1'b0; WBM_ERR_I = 1'b0;
    if (WBM_CYC_O && WBM_STB_O && !silent) begin
      beat_no++;
      if (beat_no == err_at)      WBM_ERR_I = 1'b1;
      else if (beat_no == rty_at) WBM_RTY_I = 1'b1;
      else begin
        WBM_ACK_I = 1'b1;
        WBM_DAT_I = rd_pat(WBM_ADR_O);
      end
    end
  end

  // Monitor: logs acked beats, read returns, pulses and CYC-low runs
  always @(negedge WB_CLK) begin
    #1;
    if (WBM_ACK_I && WBM_CYC_O && WBM_STB_O)
      got_q.push_back('{adr: WBM_ADR_O, cti: WBM_CTI_O, we: WBM_WE_O,
                        dat: (WBM_WE_O ? WBM_DAT_O : 32'h0), ch: WR_CH[0]});
    if (WR_READY) wr_rdy_cnt++;
    if (RD_VALID) got_rd.push_back('{dat: RD_DAT, ch: RD_CH[0]});
    for (int c = 0; c < 2; c++) begin
      done_cnt[c] += int'(CH_DONE[c]);
      err_cnt[c]  += int'(CH_ERR[c]);
    end
    if (WBM_CYC_O) begin
      if (cyc_seen && low_run > 0) gaps.push_back(low_run);
      low_run  = 0;
      cyc_seen = 1'b1;
    end else if (cyc_seen) begin
      low_run++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge WB_CLK);
    WB_RST = 1'b1; CH_REQ = '0;
    repeat (3) @(negedge WB_CLK);
    WB_RST = 1'b0;
    exp_q.delete(); got_q.delete(); exp_rd.delete(); got_rd.delete(); gaps.delete();
    low_run = 0; cyc_seen = 0; wr_rdy_cnt = 0; beat_no = 0; rty_at = 0; err_at = 0;
    silent = 0; stall_en = 0;
    done_cnt = '{0, 0}; err_cnt = '{0, 0};
  endtask

  task automatic set_ch(input int ch, input bit we, input logic [31:0] adr, input int len);
    CH_WE[ch] = we;
    CH_ADDR[ch*32 +: 32] = adr;
    CH_LEN[ch*LEN_W +: LEN_W] = LEN_W'(len);
  endtask

  task automatic pulse(input logic [1:0] mask);
    @(negedge WB_CLK);
    CH_REQ = mask;
    @(negedge WB_CLK);
    CH_REQ = '0;
  endtask

  task automatic wait_quiet(input int budget, input string nm);
    int n = 0;
    @(negedge WB_CLK);
    while ((CH_BUSY != 2'b00 || WBM_CYC_O) && n < budget) begin
      @(negedge WB_CLK);
      n++;
    end
    repeat (3) @(negedge WB_CLK);
    total++;
    if (CH_BUSY !== 2'b00) begin
      bad++;
      $display("FAIL %s_quiet: busy=%b want 00 within %0d cycles", nm, CH_BUSY, budget);
    end
  endtask

  task automatic test_reset();
    WB_RST = 1'b1;
    repeat (3) @(negedge WB_CLK);
    total++; if (WBM_CYC_O !== 1'b0) begin bad++; $display("FAIL rst_cyc got=%b want=0", WBM_CYC_O); end
    total++; if (WBM_STB_O !== 1'b0) begin bad++; $display("FAIL rst_stb got=%b want=0", WBM_STB_O); end
    total++; if (CH_BUSY !== 2'b00) begin bad++; $display("FAIL rst_busy got=%b want=00", CH_BUSY); end
    total++; if ({CH_DONE, CH_ERR} !== 4'b0) begin bad++; $display("FAIL rst_pulse got=%b want=0000", {CH_DONE, CH_ERR}); end
    total++; if ({RD_VALID, WR_READY} !== 2'b00) begin bad++; $display("FAIL rst_valid got=%b want=00", {RD_VALID, WR_READY}); end
    total++; if (WBM_ADR_O !== 32'h0) begin bad++; $display("FAIL rst_adr got=%h want=0", WBM_ADR_O); end
    do_reset();
  endtask

  // ch0 write of 20 words -> bursts of 16 + 4; a re-request while busy is ignored
  task automatic test_write_burst();
    beat_t e, g;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      logic [31:0] a = 32'h1000 + 32'(4 * i);
      exp_q.push_back('{adr: a, cti: ((i == 15 || i == 19) ? 3'b111 : 3'b010), we: 1'b1, dat: wr_pat(a), ch: 1'b0});
    end
    set_ch(0, 1'b1, 32'h1000, 20);
    pulse(2'b01);
    repeat (4) @(negedge WB_CLK);
    set_ch(0, 1'b0, 32'h9000, 5);
    pulse(2'b01);
    wait_quiet(300, "wr");
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL wr_beats count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total++;
      if (g !== e) begin bad++; $display("FAIL wr_beat got adr=%h cti=%b we=%b dat=%h want adr=%h cti=%b we=%b dat=%h", g.adr, g.cti, g.we, g.dat, e.adr, e.cti, e.we, e.dat); end
    end
    total++; if (gaps.size() != 1 || gaps[0] != 1) begin bad++; $display("FAIL wr_gap got n=%0d first=%0d want n=1 first=1", gaps.size(), (gaps.size() > 0) ? gaps[0] : -1); end
    total++; if (done_cnt[0] != 1 || err_cnt[0] != 0) begin bad++; $display("FAIL wr_done got done=%0d err=%0d want 1 0", done_cnt[0], err_cnt[0]); end
    total++; if (wr_rdy_cnt != 20) begin bad++; $display("FAIL wr_ready got=%0d want=20", wr_rdy_cnt); end
  endtask

  // Two reads requested together: bursts alternate ch0,ch1,ch0,ch1
  task automatic test_round_robin();
    beat_t e, g;
    rd_t er, gr;
    int seg[4][3] = '{'{0, 0, 16}, '{1, 0, 16}, '{0, 16, 2}, '{1, 16, 2}};
    do_reset();
    foreach (seg[s]) begin
      for (int i = 0; i < seg[s][2]; i++) begin
        logic [31:0] a = (seg[s][0] == 0 ? 32'h2000 : 32'h8000) + 32'(4 * (seg[s][1] + i));
        exp_q.push_back('{adr: a, cti: ((i == seg[s][2] - 1) ? 3'b111 : 3'b010), we: 1'b0, dat: 32'h0, ch: seg[s][0][0]});
        exp_rd.push_back('{dat: rd_pat(a), ch: seg[s][0][0]});
      end
    end
    set_ch(0, 1'b0, 32'h2000, 18);
    set_ch(1, 1'b0, 32'h8000, 18);
    pulse(2'b11);
    wait_quiet(400, "rr");
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rr_beats count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total++;
      if (g !== e) begin bad++; $display("FAIL rr_beat got adr=%h cti=%b ch=%0d want adr=%h cti=%b ch=%0d", g.adr, g.cti, g.ch, e.adr, e.cti, e.ch); end
    end
    total++; if (got_rd.size() != exp_rd.size()) begin bad++; $display("FAIL rr_rd count got=%0d want=%0d", got_rd.size(), exp_rd.size()); end
    while (exp_rd.size() > 0 && got_rd.size() > 0) begin
      er = exp_rd.pop_front(); gr = got_rd.pop_front();
      total++;
      if (gr !== er) begin bad++; $display("FAIL rr_rd got dat=%h ch=%0d want dat=%h ch=%0d", gr.dat, gr.ch, er.dat, er.ch); end
    end
    total++; if (done_cnt[0] != 1 || done_cnt[1] != 1) begin bad++; $display("FAIL rr_done got %0d %0d want 1 1", done_cnt[0], done_cnt[1]); end
  endtask

  // Write of 8 words with RTY on the third strobe and random wait beats
  task automatic test_retry();
    beat_t e, g;
    do_reset();
    rty_at = 3;
    stall_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a = 32'h3000 + 32'(4 * i);
      exp_q.push_back('{adr: a, cti: ((i == 7) ? 3'b111 : 3'b010), we: 1'b1, dat: wr_pat(a), ch: 1'b1});
    end
    set_ch(1, 1'b1, 32'h3000, 8);
    pulse(2'b10);
    wait_quiet(300, "rty");
    stall_en = 1'b0;
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rty_beats count got=%0d want=%0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      total++;
      if (g !== e) begin bad++; $display("FAIL rty_beat got adr=%h cti=%b dat=%h want adr=%h cti=%b dat=%h", g.adr, g.cti, g.dat, e.adr, e.cti, e.dat); end
    end
    total++; if (gaps.size() != 1 || gaps[0] != 4) begin bad++; $display("FAIL rty_gap got n=%0d first=%0d want n=1 first=4", gaps.size(), (gaps.size() > 0) ? gaps[0] : -1); end
    total++; if (wr_rdy_cnt != 8) begin bad++; $display("FAIL rty_ready got=%0d want=8", wr_rdy_cnt); end
    total++; if (done_cnt[1] != 1) begin bad++; $display("FAIL rty_done got=%0d want=1", done_cnt[1]); end
  endtask

  // ERR on second beat of a 10-word read
  task automatic test_error();
    rd_t gr;
    do_reset();
    err_at = 2;
    set_ch(1, 1'b0, 32'h4000, 10);
    pulse(2'b10);
    wait_quiet(100, "err");
    total++; if (err_cnt[1] != 1) begin bad++; $display("FAIL err_pulse got=%0d want=1", err_cnt[1]); end
    total++; if (done_cnt[1] != 0) begin bad++; $display("FAIL err_nodone got=%0d want=0", done_cnt[1]); end
    total++; if (got_rd.size() != 1) begin bad++; $display("FAIL err_rdcount got=%0d want=1", got_rd.size()); end
    if (got_rd.size() > 0) begin
      gr = got_rd.pop_front();
      total++;
      if (gr.dat !== rd_pat(32'h4000) || gr.ch !== 1'b1) begin bad++; $display("FAIL err_rd got dat=%h ch=%0d want dat=%h ch=1", gr.dat, gr.ch, rd_pat(32'h4000)); end
    end
  endtask

  // Zero-length request, then reset in the middle of a burst
  task automatic test_len0_and_reset();
    int n = 0;
    do_reset();
    set_ch(0, 1'b0, 32'h6000, 0);
    pulse(2'b01);
    total++; if (CH_BUSY[0] !== 1'b1) begin bad++; $display("FAIL len0_busy got=%b want=1", CH_BUSY[0]); end
    wait_quiet(50, "len0");
    total++; if (done_cnt[0] != 1) begin bad++; $display("FAIL len0_done got=%0d want=1", done_cnt[0]); end
    total++; if (cyc_seen) begin bad++; $display("FAIL len0_cyc got=1 want=0"); end
    set_ch(1, 1'b0, 32'h7000, 16);
    pulse(2'b10);
    while (got_q.size() < 5 && n < 100) begin @(negedge WB_CLK); n++; end
    total++; if (got_q.size() < 5) begin bad++; $display("FAIL mid_start beats=%0d want>=5", got_q.size()); end
    WB_RST = 1'b1;
    @(posedge WB_CLK); #1;
    total++; if (WBM_CYC_O !== 1'b0 || CH_BUSY !== 2'b00) begin bad++; $display("FAIL mid_rst got cyc=%b busy=%b want 0 00", WBM_CYC_O, CH_BUSY); end
    @(negedge WB_CLK);
    WB_RST = 1'b0;
    cyc_seen = 0;
    repeat (20) @(negedge WB_CLK);
    total++; if (done_cnt[1] != 0 || err_cnt[1] != 0) begin bad++; $display("FAIL mid_pulse got done=%0d err=%0d want 0 0", done_cnt[1], err_cnt[1]); end
    total++; if (cyc_seen) begin bad++; $display("FAIL mid_cyc got=1 want=0"); end
  endtask

`ifdef WB_DMA_TIMEOUT_EN
  // Silent bridge: abort 256 cycles after the strobe first appears
  task automatic test_timeout();
    int n = 0, t0 = -1, t1 = -1;
    do_reset();
    silent = 1'b1;
    set_ch(0, 1'b0, 32'h5000, 4);
    pulse(2'b01);
    while (t1 < 0 && n < 600) begin
      if (t0 < 0 && WBM_STB_O) t0 = n;
      if (CH_ERR[0]) t1 = n;
      @(negedge WB_CLK); #2;
      n++;
    end
    silent = 1'b0;
    total++; if (t0 < 0 || t1 < 0 || (t1 - t0) != 256) begin bad++; $display("FAIL timeout got=%0d want=256", t1 - t0); end
    wait_quiet(50, "tmo");
  endtask
`endif

  initial begin
    test_reset();
    test_write_burst();
    test_round_robin();
    test_retry();
    test_error();
    test_len0_and_reset();
`ifdef WB_DMA_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
